// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU opcodes, writeback selects, reset PC and
// the D/E pipeline field bundle.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [3:0] {
    AluAnd  = 4'd0,
    AluOr   = 4'd1,
    AluAddu = 4'd2,
    AluSll  = 4'd3,
    AluAndn = 4'd4,
    AluOrn  = 4'd5,
    AluSubu = 4'd6,
    AluSlt  = 4'd7,
    AluLui  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    MemtoRegAlu = 2'd0,
    MemtoRegMem = 2'd1,
    MemtoRegPc8 = 2'd2
  } mem_to_reg_e;

  // Everything latched into E except the PC, which survives a bubble.
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  a3;
    logic [4:0]  shamt;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  tnew;
  } de_fields_t;

endpackage

// File: rtl/fwd_mux.sv
// Three-way operand forwarding select: M stage beats W stage, and $0 is
// never forwarded.
module fwd_mux (
  input  logic [4:0]  sel_addr,
  input  logic [31:0] reg_data,
  input  logic        m_en,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic        w_en,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (sel_addr != 5'd0) begin
      if (m_en && (m_addr == sel_addr)) begin
        fwd_data = m_data;
      end else if (w_en && (w_addr == sel_addr)) begin
        fwd_data = w_data;
      end
    end
  end

endmodule

// File: rtl/de_pipe_reg.sv
// D/E pipeline register with bubble insertion and E-stage operand select.
// Define DE_FWD_EN to build the M/W forwarding muxes.
module de_pipe_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [31:0] D_ext,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [4:0]  D_A3,
  input  logic [4:0]  D_shamt,
  input  logic [3:0]  D_ALUControl,
  input  logic        D_ALUSrc,
  input  logic        D_RegWrite,
  input  logic        D_MemWrite,
  input  logic [1:0]  D_MemtoReg,
  input  logic [1:0]  D_Tnew,
  input  logic        M_fwd_en,
  input  logic        W_fwd_en,
  input  logic [4:0]  M_fwd_addr,
  input  logic [4:0]  W_fwd_addr,
  input  logic [31:0] M_fwd_data,
  input  logic [31:0] W_fwd_data,
  output logic [31:0] E_A,
  output logic [31:0] E_B,
  output logic [31:0] E_RT_data,
  output logic [31:0] E_PC,
  output logic [4:0]  E_rs,
  output logic [4:0]  E_rt,
  output logic [4:0]  E_A3,
  output logic [4:0]  E_shamt,
  output logic [3:0]  E_ALUControl,
  output logic        E_RegWrite,
  output logic        E_MemWrite,
  output logic [1:0]  E_MemtoReg,
  output logic [1:0]  E_Tnew,
  output logic [31:0] E_bubble_cnt
);

  de_fields_t  d_fields;
  de_fields_t  e_q;
  logic [31:0] pc_q;
  logic [31:0] bubble_cnt_q;

  always_comb begin
    d_fields = '{
      rd1:         D_RD1,
      rd2:         D_RD2,
      ext:         D_ext,
      rs:          D_rs,
      rt:          D_rt,
      a3:          D_A3,
      shamt:       D_shamt,
      alu_control: D_ALUControl,
      alu_src:     D_ALUSrc,
      reg_write:   D_RegWrite,
      mem_write:   D_MemWrite,
      mem_to_reg:  D_MemtoReg,
      tnew:        D_Tnew
    };
  end

  // A bubble keeps the PC flowing so E still knows where it sits in the stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      pc_q         <= RESET_PC;
      bubble_cnt_q <= '0;
    end else if (stall) begin
      e_q          <= '0;
      pc_q         <= D_PC;
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else begin
      e_q          <= d_fields;
      pc_q         <= D_PC;
    end
  end

  logic [31:0] rs_data;
  logic [31:0] rt_data;

`ifdef DE_FWD_EN
  fwd_mux u_fwd_rs (
    .sel_addr (e_q.rs),
    .reg_data (e_q.rd1),
    .m_en     (M_fwd_en),
    .m_addr   (M_fwd_addr),
    .m_data   (M_fwd_data),
    .w_en     (W_fwd_en),
    .w_addr   (W_fwd_addr),
    .w_data   (W_fwd_data),
    .fwd_data (rs_data)
  );

  fwd_mux u_fwd_rt (
    .sel_addr (e_q.rt),
    .reg_data (e_q.rd2),
    .m_en     (M_fwd_en),
    .m_addr   (M_fwd_addr),
    .m_data   (M_fwd_data),
    .w_en     (W_fwd_en),
    .w_addr   (W_fwd_addr),
    .w_data   (W_fwd_data),
    .fwd_data (rt_data)
  );
`else
  // Without forwarding the hazard unit stalls every RAW dependence.
  logic unused_fwd;
  assign unused_fwd = ^{M_fwd_en, W_fwd_en, M_fwd_addr, W_fwd_addr, M_fwd_data, W_fwd_data};
  assign rs_data = e_q.rd1;
  assign rt_data = e_q.rd2;
`endif

  assign E_A          = rs_data;
  assign E_RT_data    = rt_data;
  assign E_B          = e_q.alu_src ? e_q.ext : rt_data;
  assign E_PC         = pc_q;
  assign E_rs         = e_q.rs;
  assign E_rt         = e_q.rt;
  assign E_A3         = e_q.a3;
  assign E_shamt      = e_q.shamt;
  assign E_ALUControl = e_q.alu_control;
  assign E_RegWrite   = e_q.reg_write;
  assign E_MemWrite   = e_q.mem_write;
  assign E_MemtoReg   = e_q.mem_to_reg;
  assign E_Tnew       = e_q.tnew;
  assign E_bubble_cnt = bubble_cnt_q;

endmodule
